// File: rtl/rf_xbar.sv
`default_nettype none
// ============================================================================
// Module   : rf_xbar
// Purpose  : Data register file R0..R(2**RF_ADDRSIZE-1) with its crossbar.
//            It has two combinational read ports (Rx, Ry) and one write port.
//            The write address and result source are captured in decode.
//            The result is selected from the execution units in execute and
//            written on the edge that closes the execute cycle.
// Build    : RF_WRT_FWD_EN (macro). When it is defined, an execute-to-decode
//            forwarding path bypasses the array for a pending write.
//            When it is undefined, reads come from the array only, and the
//            sequencer must stall on rf_ps_wrt_pend plus an address match.
// Ports    :
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   ps_rf_rdx_add  in   Rx read address (decode cycle)
//   ps_rf_rdy_add  in   Ry read address (decode cycle)
//   ps_rf_wrt_en   in   decode instruction writes Rn
//   ps_rf_wrt_add  in   Rn destination address (decode cycle)
//   ps_rf_wrt_src  in   result source: 00 ALU, 01 MUL, 10 SHF, 11 bus
//   alu_xb_dt      in   ALU result (execute cycle)
//   mul_xb_dt      in   multiplier result (execute cycle)
//   shf_xb_dt      in   shifter result (execute cycle)
//   bus_rf_dt      in   bus/load data (execute cycle)
//   xb_dtx         out  Rx operand (combinational)
//   xb_dty         out  Ry operand (combinational)
//   rf_ps_wrt_pend out  a write is in its execute cycle
// Revision : 1.0 - initial release
// ============================================================================
module rf_xbar #(
  parameter int RF_DATASIZE = 16,
  parameter int RF_ADDRSIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RF_ADDRSIZE-1:0] ps_rf_rdx_add,
  input  logic [RF_ADDRSIZE-1:0] ps_rf_rdy_add,
  input  logic                   ps_rf_wrt_en,
  input  logic [RF_ADDRSIZE-1:0] ps_rf_wrt_add,
  input  logic [1:0]             ps_rf_wrt_src,
  input  logic [RF_DATASIZE-1:0] alu_xb_dt,
  input  logic [RF_DATASIZE-1:0] mul_xb_dt,
  input  logic [RF_DATASIZE-1:0] shf_xb_dt,
  input  logic [RF_DATASIZE-1:0] bus_rf_dt,
  output logic [RF_DATASIZE-1:0] xb_dtx,
  output logic [RF_DATASIZE-1:0] xb_dty,
  output logic                   rf_ps_wrt_pend
);

  localparam int         c_depth   = 2 ** RF_ADDRSIZE;
  localparam logic [1:0] c_src_alu = 2'b00;
  localparam logic [1:0] c_src_mul = 2'b01;
  localparam logic [1:0] c_src_shf = 2'b10;

  logic [RF_DATASIZE-1:0] r_regs [c_depth];
  logic                   r_wrt_en_q;
  logic [RF_ADDRSIZE-1:0] r_wrt_add_q;
  logic [1:0]             r_wrt_src_q;
  logic [RF_DATASIZE-1:0] w_wrt_dt;

  // Result source mux. Every encoding selects an input, so 11 falls to the bus.
  always_comb begin
    w_wrt_dt = bus_rf_dt;
    case (r_wrt_src_q)
      c_src_alu: w_wrt_dt = alu_xb_dt;
      c_src_mul: w_wrt_dt = mul_xb_dt;
      c_src_shf: w_wrt_dt = shf_xb_dt;
      default:   w_wrt_dt = bus_rf_dt;
    endcase
  end

  // The decode-stage write controls are captured every cycle, so a bubble
  // clears r_wrt_en_q. Reset clears r_wrt_en_q asynchronously, which drops
  // any write already in execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrt_en_q  <= 1'b0;
      r_wrt_add_q <= '0;
      r_wrt_src_q <= '0;
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wrt_en_q  <= ps_rf_wrt_en;
      r_wrt_add_q <= ps_rf_wrt_add;
      r_wrt_src_q <= ps_rf_wrt_src;
      if (r_wrt_en_q) begin
        r_regs[r_wrt_add_q] <= w_wrt_dt;
      end
    end
  end

  assign rf_ps_wrt_pend = r_wrt_en_q;

`ifdef RF_WRT_FWD_EN
  // The execute-cycle result has not reached the array yet. Bypass it
  // straight to a read port that addresses the same register.
  logic w_fwd_x;
  logic w_fwd_y;

  assign w_fwd_x = r_wrt_en_q && (r_wrt_add_q == ps_rf_rdx_add);
  assign w_fwd_y = r_wrt_en_q && (r_wrt_add_q == ps_rf_rdy_add);
  assign xb_dtx  = w_fwd_x ? w_wrt_dt : r_regs[ps_rf_rdx_add];
  assign xb_dty  = w_fwd_y ? w_wrt_dt : r_regs[ps_rf_rdy_add];
`else
  assign xb_dtx  = r_regs[ps_rf_rdx_add];
  assign xb_dty  = r_regs[ps_rf_rdy_add];
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_xbar
// Purpose  : Directed bench for rf_xbar. It covers reset, the source mux,
//            write latency, forwarding or stale reads (RF_WRT_FWD_EN),
//            write-after-write, bubbles, and cancellation by reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_xbar;

  logic        clk;
  logic        reset;
  logic [3:0]  rdx_add;
  logic [3:0]  rdy_add;
  logic        wrt_en;
  logic [3:0]  wrt_add;
  logic [1:0]  wrt_src;
  logic [15:0] alu_dt;
  logic [15:0] mul_dt;
  logic [15:0] shf_dt;
  logic [15:0] bus_dt;
  logic [15:0] dtx;
  logic [15:0] dty;
  logic        wrt_pend;

  int n_checks;
  int n_fail;

  rf_xbar #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps_rf_rdx_add  (rdx_add),
    .ps_rf_rdy_add  (rdy_add),
    .ps_rf_wrt_en   (wrt_en),
    .ps_rf_wrt_add  (wrt_add),
    .ps_rf_wrt_src  (wrt_src),
    .alu_xb_dt      (alu_dt),
    .mul_xb_dt      (mul_dt),
    .shf_xb_dt      (shf_dt),
    .bus_rf_dt      (bus_dt),
    .xb_dtx         (dtx),
    .xb_dty         (dty),
    .rf_ps_wrt_pend (wrt_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, which starts a new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a decode-cycle write request for the current cycle.
  task automatic decode(input logic en, input logic [3:0] add, input logic [1:0] src);
    wrt_en  = en;
    wrt_add = add;
    wrt_src = src;
  endtask

  // Read two registers from the array in a quiet cycle.
  task automatic read2(input string tag, input logic [3:0] ax, input logic [15:0] ex,
                       input logic [3:0] ay, input logic [15:0] ey);
    rdx_add = ax;
    rdy_add = ay;
    #1;
    check({tag, "_x"}, dtx, ex);
    check({tag, "_y"}, dty, ey);
  endtask

  logic [15:0] exp_fwd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    rdx_add  = 4'd0;
    rdy_add  = 4'd0;
    alu_dt   = 16'h0;
    mul_dt   = 16'h0;
    shf_dt   = 16'h0;
    bus_dt   = 16'h0;
    decode(1'b0, 4'd0, 2'b00);
    repeat (2) tick();
    #1;
    check("rst_pend", {15'd0, wrt_pend}, 16'h0);
    check("rst_r0x", dtx, 16'h0);
    reset = 1'b1;
    tick();

    // Basic write R5 from the multiplier and read it on both ports.
    decode(1'b1, 4'd5, 2'b01);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    mul_dt = 16'hABCD;
    #1;
    check("basic_pend", {15'd0, wrt_pend}, 16'h1);
    tick();
    #1;
    check("basic_pend_off", {15'd0, wrt_pend}, 16'h0);
    read2("basic", 4'd5, 16'hABCD, 4'd5, 16'hABCD);

    // Forwarding or stale read. Set R2 to 0001 first.
    decode(1'b1, 4'd2, 2'b00);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    alu_dt = 16'h0001;
    tick();
    decode(1'b1, 4'd2, 2'b00);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    alu_dt  = 16'h7FFF;
    rdx_add = 4'd2;
    rdy_add = 4'd2;
    #1;
`ifdef RF_WRT_FWD_EN
    exp_fwd = 16'h7FFF;
`else
    exp_fwd = 16'h0001;
`endif
    check("fwd_x", dtx, exp_fwd);
    check("fwd_y", dty, exp_fwd);
    check("fwd_pend", {15'd0, wrt_pend}, 16'h1);
    tick();
    read2("fwd_after", 4'd2, 16'h7FFF, 4'd5, 16'hABCD);

    // Source select with four back-to-back writes to R8..R11.
    alu_dt = 16'h1111;
    mul_dt = 16'h2222;
    shf_dt = 16'h3333;
    bus_dt = 16'h4444;
    decode(1'b1, 4'd8, 2'b00);
    tick();
    decode(1'b1, 4'd9, 2'b01);
    tick();
    decode(1'b1, 4'd10, 2'b10);
    tick();
    decode(1'b1, 4'd11, 2'b11);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    tick();
    read2("src_a", 4'd8, 16'h1111, 4'd9, 16'h2222);
    read2("src_b", 4'd10, 16'h3333, 4'd11, 16'h4444);

    // Write-after-write on R4 followed by a bubble.
    decode(1'b1, 4'd4, 2'b11);
    tick();
    bus_dt = 16'h00FF;
    decode(1'b1, 4'd4, 2'b10);
    tick();
    shf_dt = 16'hFF00;
    decode(1'b0, 4'd0, 2'b00);
    rdx_add = 4'd4;
    #1;
`ifdef RF_WRT_FWD_EN
    exp_fwd = 16'hFF00;
`else
    exp_fwd = 16'h00FF;
`endif
    check("waw_mid", dtx, exp_fwd);
    tick();
    #1;
    check("waw_bubble_pend", {15'd0, wrt_pend}, 16'h0);
    read2("waw_final", 4'd4, 16'hFF00, 4'd15, 16'h0000);

    // Boundary register R15 from the bus.
    decode(1'b1, 4'd15, 2'b11);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    bus_dt = 16'hBEEF;
    tick();
    read2("r15", 4'd15, 16'hBEEF, 4'd0, 16'h0000);

    // Reset mid-simulation after loading R3 with 1234.
    decode(1'b1, 4'd3, 2'b00);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    alu_dt = 16'h1234;
    tick();
    read2("r3_loaded", 4'd3, 16'h1234, 4'd3, 16'h1234);
    reset = 1'b0;
    #1;
    check("rst_mid_x", dtx, 16'h0000);
    check("rst_mid_pend", {15'd0, wrt_pend}, 16'h0);
    tick();
    reset = 1'b1;
    tick();

    // Cancel on reset: R7 is pending in execute when reset asserts.
    decode(1'b1, 4'd7, 2'b00);
    tick();
    decode(1'b0, 4'd0, 2'b00);
    alu_dt = 16'h5555;
    #1;
    check("cancel_pend_pre", {15'd0, wrt_pend}, 16'h1);
    reset = 1'b0;
    #1;
    check("cancel_pend_rst", {15'd0, wrt_pend}, 16'h0);
    #1;
    reset = 1'b1;
    tick();
    #1;
    check("cancel_pend_post", {15'd0, wrt_pend}, 16'h0);
    tick();
    read2("cancel", 4'd7, 16'h0000, 4'd4, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net so that the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rf_xbar.md
Name: rf_xbar

Overview:
- Data register file (R0–R15) with its crossbar read/write ports. Sits directly upstream of the multiplier and sibling execution units, and also consumes their results.
- Reads are combinational in the decode cycle, so units latch xb_dtx/xb_dty on the closing clock edge.
- Destination address and result source are pipelined one cycle. The result is written at the end of the execute cycle.
- Execute-to-decode forwarding removes the back-to-back RAW hazard.

Parameters:
- RF_DATASIZE, 16, width of each register and of all data buses.
- RF_ADDRSIZE, 4, register address width; depth is 2**RF_ADDRSIZE.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps_rf_rdx_add  input  RF_ADDRSIZE  Rx read address (decode cycle).
- ps_rf_rdy_add  input  RF_ADDRSIZE  Ry read address (decode cycle).
- ps_rf_wrt_en  input  1  instruction in decode writes Rn.
- ps_rf_wrt_add  input  RF_ADDRSIZE  Rn destination address (decode cycle).
- ps_rf_wrt_src  input  2  result source: 00 ALU, 01 multiplier, 10 shifter, 11 data bus.
- alu_xb_dt  input  RF_DATASIZE  ALU result, valid in execute cycle.
- mul_xb_dt  input  RF_DATASIZE  multiplier result, valid in execute cycle.
- shf_xb_dt  input  RF_DATASIZE  shifter result, valid in execute cycle.
- bus_rf_dt  input  RF_DATASIZE  data-memory/bus load data, valid in execute cycle.
- xb_dtx  output  RF_DATASIZE  Rx operand (combinational).
- xb_dty  output  RF_DATASIZE  Ry operand (combinational).
- rf_ps_wrt_pend  output  1  a write is in its execute cycle.

Behaviour:
- Reset (async, reset=0):
  - all registers cleared to 0;
  - pipelined wrt_en cleared to 0, which cancels any in-flight write;
  - wrt_add and wrt_src cleared to 0;
  - rf_ps_wrt_pend = 0; xb_dtx and xb_dty read R0 = 0 when addresses are 0.
- Decode cycle N, on the posedge ending N:
  - wrt_en_q <= ps_rf_wrt_en;
  - wrt_add_q <= ps_rf_wrt_add;
  - wrt_src_q <= ps_rf_wrt_src.
  - These pipeline registers update unconditionally every cycle, so a bubble (ps_rf_wrt_en=0) clears wrt_en_q.
- Execute cycle N+1:
  - wrt_dt = mux(wrt_src_q) of alu_xb_dt / mul_xb_dt / shf_xb_dt / bus_rf_dt;
  - rf_ps_wrt_pend = wrt_en_q;
  - on the posedge ending N+1, if wrt_en_q, then R[wrt_add_q] <= wrt_dt.
- Write latency: 2 edges from decode. The written value is visible from the array starting cycle N+2.
- Reads:
  - xb_dtx = (wrt_en_q && wrt_add_q==ps_rf_rdx_add) ? wrt_dt : R[ps_rf_rdx_add]; xb_dty likewise with ps_rf_rdy_add.
  - The forward path is purely combinational. There is no read enable, and outputs always reflect the current addresses.
- Simultaneous events:
  - Rx and Ry may address the same register; both outputs then carry the same value.
  - A decode-cycle write to Rk coexisting with an execute-cycle write to Rk is legal. The older write lands first, and the newer one lands one cycle later (last writer wins).
- No structural hazards: 1 write port, 2 read ports, one write per cycle maximum.
- Source mux is full-case; every wrt_src_q value selects a defined input. Results are written unmodified (no width change, no sign extension).
- Reset deasserted mid-pipeline: the first decode after release behaves as after a bubble; no spurious write occurs.

Optional Feature:
- RF_WRT_FWD_EN defined: the forwarding path above is present.
- Not defined:
  - xb_dtx/xb_dty = R[addr] only; a read in N+1 of a register written by N returns the stale value;
  - the sequencer must stall one cycle using rf_ps_wrt_pend together with a matching address;
  - rf_ps_wrt_pend is unchanged in both builds.

Test Plan:
- Reset, then read: pulse reset low mid-simulation after loading R3=16'h1234 → xb_dtx with rdx_add=3 returns 16'h0000; rf_ps_wrt_pend=0.
- Basic write/read: decode wrt_en=1, add=5, src=01; next cycle mul_xb_dt=16'hABCD → from cycle N+2, rdx_add=5 gives 16'hABCD and rdy_add=5 gives 16'hABCD.
- Forwarding (RF_WRT_FWD_EN): R2=16'h0001; decode write R2 from ALU; in N+1 alu_xb_dt=16'h7FFF and rdx_add=2 → xb_dtx=16'h7FFF in the same cycle. Without the macro: 16'h0001, with rf_ps_wrt_pend=1.
- Source select: four back-to-back writes to R8..R11 with src 00/01/10/11 and inputs 16'h1111/2222/3333/4444 → R8..R11 hold 16'h1111, 16'h2222, 16'h3333, 16'h4444.
- Write-after-write and bubble: decode write R4 (bus 16'h00FF), then write R4 (shifter 16'hFF00), then a bubble → R4=16'hFF00 and rf_ps_wrt_pend=0 in the bubble's execute cycle.
- Cancel on reset: decode write R7 (16'h5555 pending), assert reset during the execute cycle, release → R7=16'h0000 and no write occurs after release.
